sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 85 ++++++++
 tb/tb_sync_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags.
// Storage is a DEPTH x DATA_WIDTH register array addressed by wrapping pointers.
// The pointers carry one extra wrap bit, so all DEPTH entries are usable.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   w_en      - write request; gated internally by full
//   r_en      - read request; gated internally by empty
//   data_in   - write data, sampled with w_en
//   data_out  - read data, valid one clock after an accepted read, else held
//   full      - DEPTH entries stored
//   empty     - no entries stored
module sync_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_ok, rd_ok;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  // Same address with differing wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Both requests are qualified by the pre-edge flags: no fall-through on
  // empty, and a write into a full FIFO is dropped even when a read frees a slot.
  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  assign data_out = data_out_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      data_out_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= data_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized scoreboard bench for sync_fifo (DEPTH=8, 8-bit data).
// The driver applies inputs on the falling edge and updates a queue-based
// reference model; accepted reads push their expected data into a scoreboard
// queue that a separate monitor pops after each rising edge.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model [$];   // contents of the FIFO as seen after the pending edge
  logic [DW-1:0] exp_q [$];   // scoreboard of expected read data
  logic [DW-1:0] last_out = '0;
  bit            rd_fire = 1'b0;
  bit            mon_en  = 1'b0;
  int            tests   = 0;
  int            failed  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model sees the request against pre-edge occupancy.
  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d);
    bit wr_ok, rd_ok;
    @(negedge clk);
    w_en    = w;
    r_en    = r;
    data_in = d;
    wr_ok = w && (model.size() < DEPTH);
    rd_ok = r && (model.size() > 0);
    if (rd_ok) exp_q.push_back(model.pop_front());
    if (wr_ok) model.push_back(d);
    rd_fire = rd_ok;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    mon_en = 1'b0;
    w_en   = 1'b0;
    r_en   = 1'b0;
    rst_n  = 1'b0;
    model.delete();
    exp_q.delete();
    last_out = '0;
    rd_fire  = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_dout", 32'(data_out), 32'd0);
    mon_en = 1'b1;
  endtask

  task automatic drain();
    while (model.size() > 0) cycle(1'b0, 1'b1, '0);
  endtask

  // Monitor: consumes scoreboard entries on accepted reads, otherwise expects hold.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (rd_fire) begin
        rd_fire = 1'b0;
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          last_out = exp_q.pop_front();
          chk("rdata", 32'(data_out), 32'(last_out));
        end
      end else begin
        chk("dout_hold", 32'(data_out), 32'(last_out));
      end
      chk("empty", 32'(empty), 32'(model.size() == 0));
      chk("full", 32'(full), 32'(model.size() == DEPTH));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 10 cycles.
    do_reset(10);

    // Fill, overflow attempt, drain, and an extra read on empty.
    for (int unsigned i = 1; i <= 8; i++) cycle(1'b1, 1'b0, DW'(i * 8'h11));
    cycle(1'b1, 1'b0, 8'h99);
    for (int unsigned i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    @(posedge clk);
    #2;
    chk("read_on_empty_holds", 32'(data_out), 32'h88);

    // Alternating traffic: writes on even cycles 0..29, reads on even cycles from 10.
    do_reset(2);
    for (int unsigned c = 0; c < 40; c++) begin
      cycle((c < 30) && (c % 2 == 0), (c >= 10) && (c % 2 == 0), DW'($urandom));
    end
    drain();

    // Wrap-around: 20 write/read pairs.
    for (int unsigned i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, DW'($urandom));
      cycle(1'b0, 1'b1, '0);
    end

    // Simultaneous requests with 4 entries stored.
    for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'($urandom));
    for (int unsigned i = 0; i < 5; i++) cycle(1'b1, 1'b1, DW'($urandom));
    drain();
    // On empty only the write happens; data_out holds.
    cycle(1'b1, 1'b1, 8'hAB);
    // Fill to full, then simultaneous: only the read happens, 0xCD dropped.
    while (model.size() < DEPTH) cycle(1'b1, 1'b0, DW'($urandom));
    cycle(1'b1, 1'b1, 8'hCD);
    drain();

    // Random traffic.
    for (int unsigned i = 0; i < 300; i++) begin
      cycle(($urandom % 3) != 0, ($urandom % 2) != 0, DW'($urandom));
    end
    drain();

    // Asynchronous reset mid-cycle with 3 entries stored.
    for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'($urandom));
    cycle(1'b0, 1'b1, '0);
    @(negedge clk);
    mon_en = 1'b0;
    w_en   = 1'b0;
    r_en   = 1'b0;
    #2;
    chk("pre_async_reset_empty", 32'(empty), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_empty", 32'(empty), 32'd1);
    chk("async_reset_full", 32'(full), 32'd0);
    chk("async_reset_dout", 32'(data_out), 32'd0);
    do_reset(3);

    // First write after reset lands in entry 0 and reads back first.
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
